// File: rtl/led_pwm_pkg.sv
// Shared constants for the multi-channel LED PWM driver: channel modes and
// the breathe generator's triangle direction.
package led_pwm_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } breathe_state_e;

endpackage

// File: rtl/led_pwm_breathe.sv
// Shared triangle generator: the level ramps 0..max..0 one step per
// 2^P_BREATHE_SHIFT PWM periods, never wrapping.
module led_pwm_breathe
  import led_pwm_pkg::*;
#(
  parameter int P_PWM_BITS      = 8,
  parameter int P_BREATHE_SHIFT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_boundary,
  output logic [P_PWM_BITS-1:0] o_level,
  output breathe_state_e        o_state
);

  // A zero shift still needs a 1-bit prescaler that simply never advances.
  localparam int PRE_W = (P_BREATHE_SHIFT > 0) ? P_BREATHE_SHIFT : 1;
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'((1 << P_BREATHE_SHIFT) - 1);
  localparam logic [P_PWM_BITS-1:0] LVL_MAX  = '1;

  logic [PRE_W-1:0] r_pre;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre   <= '0;
      o_level <= '0;
      o_state <= BR_UP;
    end else if (i_boundary) begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        case (o_state)
          BR_UP: begin
            if (o_level == LVL_MAX) begin
              o_state <= BR_DOWN;
              o_level <= LVL_MAX - 1'b1;
            end else begin
              o_level <= o_level + 1'b1;
            end
          end
          BR_DOWN: begin
            if (o_level == '0) begin
              o_state <= BR_UP;
              o_level <= {{(P_PWM_BITS-1){1'b0}}, 1'b1};
            end else begin
              o_level <= o_level - 1'b1;
            end
          end
          default: o_state <= BR_UP;
        endcase
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pwm_rgb.sv
// Multi-channel LED driver: one free-running counter, per-channel shadowed
// {mode, duty} that goes live on each PWM period boundary, registered outputs.
module led_pwm_rgb
  import led_pwm_pkg::*;
#(
  parameter int P_CHANNELS      = 3,
  parameter int P_PWM_BITS      = 8,
  parameter int P_CNT_BITS      = 26,
  parameter int P_BLINK_BIT     = 24,
  parameter int P_BREATHE_SHIFT = 4,
  localparam int CH_W = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // i_wr_en is a fire-and-forget strobe with no ready: every write cycle lands
  // in the shadow of i_wr_ch, or is dropped when i_wr_ch names no channel.
  input  logic                  i_wr_en,
  input  logic [CH_W-1:0]       i_wr_ch,
  input  logic [1:0]            i_wr_mode,
  input  logic [P_PWM_BITS-1:0] i_wr_duty,
  output logic [P_CHANNELS-1:0] o_led,
  output logic                  o_period,
  output breathe_state_e        o_breathe_state
);

  logic [P_CNT_BITS-1:0] r_cnt;
  logic [P_PWM_BITS-1:0] phase;
  logic                  boundary;
  logic [P_PWM_BITS-1:0] level;
  logic [P_CHANNELS-1:0] led_next;

  assign phase    = r_cnt[P_PWM_BITS-1:0];
  assign boundary = &phase;

  led_pwm_breathe #(
    .P_PWM_BITS      (P_PWM_BITS),
    .P_BREATHE_SHIFT (P_BREATHE_SHIFT)
  ) u_breathe (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_boundary (boundary),
    .o_level    (level),
    .o_state    (o_breathe_state)
  );

  for (genvar g = 0; g < P_CHANNELS; g++) begin : g_ch
    logic [1:0]            r_sh_mode;
    logic [1:0]            r_act_mode;
    logic [P_PWM_BITS-1:0] r_sh_duty;
    logic [P_PWM_BITS-1:0] r_act_duty;
    logic [P_PWM_BITS-1:0] eff;
    logic                  wr_hit;

    assign wr_hit = i_wr_en && (i_wr_ch == CH_W'(g));

    // Active takes the pre-write shadow, so a boundary-clock write waits a period.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_sh_mode  <= MODE_OFF;
        r_sh_duty  <= '0;
        r_act_mode <= MODE_OFF;
        r_act_duty <= '0;
      end else begin
        if (wr_hit) begin
          r_sh_mode <= i_wr_mode;
          r_sh_duty <= i_wr_duty;
        end
        if (boundary) begin
          r_act_mode <= r_sh_mode;
          r_act_duty <= r_sh_duty;
        end
      end
    end

    always_comb begin
      eff = '0;
      case (r_act_mode)
        MODE_OFF:     eff = '0;
        MODE_ON:      eff = r_act_duty;
        MODE_BLINK:   eff = r_cnt[P_BLINK_BIT] ? r_act_duty : '0;
        MODE_BREATHE: eff = (level < r_act_duty) ? level : r_act_duty;
        default:      eff = '0;
      endcase
    end

    assign led_next[g] = (phase < eff);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      o_led    <= '0;
      o_period <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
      o_led    <= led_next;
      o_period <= boundary;
    end
  end

endmodule

// File: tb/tb_led_pwm_rgb.sv
// Bench for led_pwm_rgb: directed and random writes against an arithmetic
// model of counter, boundary-loaded channel settings and triangle level.
module tb_led_pwm_rgb;
  import led_pwm_pkg::*;

  localparam int NCH     = 3;
  localparam int PWM     = 4;
  localparam int CNTB    = 8;
  localparam int BLINK   = 6;
  localparam int SHIFT   = 0;
  localparam int PER     = 1 << PWM;
  localparam int MAXL    = PER - 1;
  localparam int CNT_MOD = 1 << CNTB;
  localparam int PRE_MAX = (1 << SHIFT) - 1;

  // clock/reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [1:0]     wr_mode = '0;
  logic [PWM-1:0] wr_duty = '0;
  logic [NCH-1:0] led;
  logic           period;
  breathe_state_e bstate;

  led_pwm_rgb #(
    .P_CHANNELS      (NCH),
    .P_PWM_BITS      (PWM),
    .P_CNT_BITS      (CNTB),
    .P_BLINK_BIT     (BLINK),
    .P_BREATHE_SHIFT (SHIFT)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wr_en         (wr_en),
    .i_wr_ch         (wr_ch),
    .i_wr_mode       (wr_mode),
    .i_wr_duty       (wr_duty),
    .o_led           (led),
    .o_period        (period),
    .o_breathe_state (bstate)
  );

  // scoreboard: entry = {breathe_down, period, led}
  localparam int W = NCH + 2;
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  int m_cnt = 0;
  int m_level = 0;
  int m_down = 0;
  int m_pre = 0;
  int sh_mode[NCH];
  int sh_duty[NCH];
  int act_mode[NCH];
  int act_duty[NCH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // reference model, evaluated on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    int phase;
    int bnd;
    int eff;
    logic [NCH-1:0] e_led;
    if (!rst_n) begin
      m_cnt   = 0;
      m_level = 0;
      m_down  = 0;
      m_pre   = 0;
      for (int i = 0; i < NCH; i++) begin
        sh_mode[i]  = 0;
        sh_duty[i]  = 0;
        act_mode[i] = 0;
        act_duty[i] = 0;
      end
      exp_q.delete();
    end else begin
      phase = m_cnt % PER;
      bnd   = (phase == MAXL);
      for (int i = 0; i < NCH; i++) begin
        case (act_mode[i])
          0:       eff = 0;
          1:       eff = act_duty[i];
          2:       eff = ((m_cnt >> BLINK) & 1) ? act_duty[i] : 0;
          default: eff = (m_level < act_duty[i]) ? m_level : act_duty[i];
        endcase
        e_led[i] = (phase < eff);
      end
      if (bnd) begin
        for (int i = 0; i < NCH; i++) begin
          act_mode[i] = sh_mode[i];
          act_duty[i] = sh_duty[i];
        end
        if (m_pre == PRE_MAX) begin
          m_pre = 0;
          if (m_down == 0) begin
            if (m_level == MAXL) begin
              m_down  = 1;
              m_level = MAXL - 1;
            end else begin
              m_level = m_level + 1;
            end
          end else begin
            if (m_level == 0) begin
              m_down  = 0;
              m_level = 1;
            end else begin
              m_level = m_level - 1;
            end
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (wr_en && (wr_ch < NCH)) begin
        sh_mode[wr_ch] = wr_mode;
        sh_duty[wr_ch] = wr_duty;
      end
      m_cnt = (m_cnt + 1) % CNT_MOD;
      exp_q.push_back({m_down[0], bnd[0], e_led});
    end
  end

  // scoreboard compare
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({(bstate == BR_DOWN), period, led} !== e) begin
        n_errors++;
        $display("FAIL scoreboard at %0t: got=%b expected=%b", $time,
                 {(bstate == BR_DOWN), period, led}, e);
      end
    end
  end

  // driver tasks
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((dut.r_cnt[PWM-1:0] != p) && (n < 4 * PER));
    if (n >= 4 * PER) begin
      n_errors++;
      $display("FAIL wait_phase(%0d) expired at %0t", p, $time);
    end
  endtask

  task automatic wait_period(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!period && (n < 4 * PER));
    if (!period) begin
      n_errors++;
      $display("FAIL wait_period expired at %0t", $time);
    end
  endtask

  task automatic write(input int ch, input int mode, input int duty);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_mode = mode[1:0];
    wr_duty = duty[PWM-1:0];
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic count_high(input int ch, input int clocks, output int n);
    n = 0;
    repeat (clocks) begin
      @(posedge clk);
      #1;
      n += led[ch];
    end
  endtask

  task automatic settle();
    wait_phase(0);
    wait_phase(0);
  endtask

  int n;
  int mx;

  initial begin
    // reset state
    #12;
    check("reset led", led, 0);
    check("reset period", period, 0);
    check("reset state", bstate, BR_UP);
    check("reset level", dut.level, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // idle
    count_high(0, 64, n);
    check("idle led", led, 0);
    wait_period(n);
    wait_period(n);
    check("period interval", n, PER);

    // ch0 ON
    @(posedge clk); #1;
    write(0, MODE_ON, 5);
    settle();
    count_high(0, PER, n);
    check("ch0 duty5", n, 5);
    write(0, MODE_ON, 0);
    settle();
    count_high(0, PER, n);
    check("ch0 duty0", n, 0);
    write(0, MODE_ON, 15);
    settle();
    count_high(0, PER, n);
    check("ch0 duty15", n, 15);

    // ch1 written on the boundary clock
    wait_phase(MAXL);
    write(1, MODE_ON, 4);
    count_high(1, PER, n);
    check("ch1 boundary write delayed", n, 0);
    count_high(1, PER, n);
    check("ch1 boundary write effect", n, 4);

    // out-of-range channel
    write(3, MODE_ON, 9);
    settle();
    count_high(2, PER, n);
    check("wr_ch=3 ignored", n, 0);

    // ch2 BLINK
    write(2, MODE_BLINK, 15);
    settle();
    count_high(2, CNT_MOD, n);
    check("ch2 blink", n, 120);
    write(2, MODE_OFF, 0);
    write(1, MODE_OFF, 0);

    // ch0 BREATHE saturating at duty 8
    write(0, MODE_BREATHE, 8);
    settle();
    mx = 0;
    repeat (2 * PER) begin
      count_high(0, PER, n);
      if (n > mx) mx = n;
    end
    check("breathe saturate", mx, 8);

    // ch0 BREATHE full duty
    write(0, MODE_BREATHE, 15);
    settle();
    repeat (2 * PER) count_high(0, PER, n);

    // random writes
    repeat (40) begin
      write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, MAXL));
      repeat ($urandom_range(0, 2 * PER)) @(posedge clk);
      #1;
    end

    // reset mid-period during BREATHE
    write(0, MODE_BREATHE, 15);
    settle();
    repeat (5 * PER + 6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset led", led, 0);
    check("midreset period", period, 0);
    check("midreset level", dut.level, 0);
    check("midreset state", bstate, BR_UP);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_period(n);
    check("first period after release", n, PER);
    count_high(0, PER, n);
    check("mode off after reset", n, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
